// File: rtl/unidade_de_controle_defs.sv
// Shared definitions for the multi-cycle controller: opcodes, FSM state
// encodings and instruction field positions.
package unidade_de_controle_defs;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LDI = 3'd1;
    localparam logic [2:0] OP_MOV = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_NOT = 3'd7;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_IMM   = 2'd1,
        S_EXEC  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    localparam int OP_HI   = 7;
    localparam int OP_LO   = 5;
    localparam int RDST_HI = 3;
    localparam int RDST_LO = 2;
    localparam int RSRC_HI = 1;
    localparam int RSRC_LO = 0;

    // Only the arithmetic opcodes are allowed to move the carry flag.
    function automatic logic updates_carry(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/ula.sv
// Combinational ALU: result and carry/borrow for the controller's opcodes.
module ula
    import unidade_de_controle_defs::*;
#(
    parameter int Size = 8
) (
    input  logic [2:0]      op,
    input  logic [Size-1:0] a,
    input  logic [Size-1:0] b,
    output logic [Size-1:0] y,
    output logic            cout
);

    logic [Size:0] ext_s;

    // Operation select; SUB reports borrow through the extended top bit.
    always_comb begin
        ext_s = {(Size+1){1'b0}};
        y     = {Size{1'b0}};
        cout  = 1'b0;
        case (op)
            OP_MOV: y = b;
            OP_ADD: begin
                ext_s = {1'b0, a} + {1'b0, b};
                y     = ext_s[Size-1:0];
                cout  = ext_s[Size];
            end
            OP_SUB: begin
                ext_s = {1'b0, a} - {1'b0, b};
                y     = ext_s[Size-1:0];
                cout  = ext_s[Size];
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_NOT: y = ~b;
            default: begin
                y    = {Size{1'b0}};
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/unidade_de_controle.sv
// Multi-cycle controller + ALU stage feeding a register bank through a
// single write port; instructions arrive over a valid/ready handshake.
module unidade_de_controle
    import unidade_de_controle_defs::*;
#(
    parameter int Size = 8
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [Size-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [Size-1:0] rd1,
    input  logic [Size-1:0] rd2,
    output logic            we,
    output logic [Size-1:0] wd,
    output logic [1:0]      a1,
    output logic [1:0]      a2,
    output logic            zero,
    output logic            carry,
    output logic            done,
    output logic            busy
);

    state_t          state_r;
    state_t          state_nx_s;
    logic [2:0]      op_r;
    logic [1:0]      rdst_r;
    logic [Size-1:0] result_r;
    logic            cout_r;
    logic            zero_r;
    logic            carry_r;
    logic            nop_done_r;
    logic [1:0]      a1_r;
    logic [1:0]      a2_r;

    logic [2:0]      op_in_s;
    logic [1:0]      rdst_in_s;
    logic [1:0]      rsrc_in_s;
    logic            in_ready_s;
    logic            busy_s;
    logic            wb_s;
    logic [Size-1:0] alu_y_s;
    logic            alu_cout_s;

    assign op_in_s   = in_data[OP_HI:OP_LO];
    assign rdst_in_s = in_data[RDST_HI:RDST_LO];
    assign rsrc_in_s = in_data[RSRC_HI:RSRC_LO];

    ula #(.Size(Size)) u_ula (
        .op   (op_r),
        .a    (rd1),
        .b    (rd2),
        .y    (alu_y_s),
        .cout (alu_cout_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; NOP completes without leaving FETCH.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (in_valid) begin
                    case (op_in_s)
                        OP_NOP:  state_nx_s = S_FETCH;
                        OP_LDI:  state_nx_s = S_IMM;
                        default: state_nx_s = S_EXEC;
                    endcase
                end else begin
                    state_nx_s = S_FETCH;
                end
            end
            S_IMM: begin
                if (in_valid) begin
                    state_nx_s = S_WB;
                end else begin
                    state_nx_s = S_IMM;
                end
            end
            S_EXEC:  state_nx_s = S_WB;
            S_WB:    state_nx_s = S_FETCH;
            default: state_nx_s = S_FETCH;
        endcase
    end

    // State-decoded control outputs.
    always_comb begin
        in_ready_s = 1'b0;
        busy_s     = 1'b1;
        wb_s       = 1'b0;
        case (state_r)
            S_FETCH: begin
                in_ready_s = 1'b1;
                busy_s     = 1'b0;
            end
            S_IMM:   in_ready_s = 1'b1;
            S_EXEC:  in_ready_s = 1'b0;
            S_WB:    wb_s = 1'b1;
            default: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b1;
                wb_s       = 1'b0;
            end
        endcase
    end

    // Datapath: field latch, result capture, address registers and flags.
    // a1/a2 are loaded one edge ahead so they are valid throughout EXEC/WB.
    always_ff @(posedge clk) begin
        if (clr) begin
            op_r       <= 3'd0;
            rdst_r     <= 2'd0;
            result_r   <= {Size{1'b0}};
            cout_r     <= 1'b0;
            zero_r     <= 1'b0;
            carry_r    <= 1'b0;
            nop_done_r <= 1'b0;
            a1_r       <= 2'd0;
            a2_r       <= 2'd0;
        end else begin
            nop_done_r <= 1'b0;
            case (state_r)
                S_FETCH: begin
                    if (in_valid) begin
                        op_r       <= op_in_s;
                        rdst_r     <= rdst_in_s;
                        nop_done_r <= (op_in_s == OP_NOP);
                        if ((op_in_s != OP_NOP) && (op_in_s != OP_LDI)) begin
                            a1_r <= rdst_in_s;
                            a2_r <= rsrc_in_s;
                        end
                    end
                end
                S_IMM: begin
                    if (in_valid) begin
                        result_r <= in_data;
                        a1_r     <= rdst_r;
                    end
                end
                S_EXEC: begin
                    result_r <= alu_y_s;
                    cout_r   <= alu_cout_s;
                end
                S_WB: begin
                    zero_r <= (result_r == {Size{1'b0}});
                    if (updates_carry(op_r)) begin
                        carry_r <= cout_r;
                    end
                end
                default: nop_done_r <= 1'b0;
            endcase
        end
    end

    // A reset landing on the WB cycle must suppress the write immediately.
    assign we       = wb_s & ~clr;
    assign done     = nop_done_r | (wb_s & ~clr);
    assign wd       = result_r;
    assign in_ready = in_ready_s;
    assign busy     = busy_s;
    assign a1       = a1_r;
    assign a2       = a2_r;
    assign zero     = zero_r;
    assign carry    = carry_r;

endmodule

// File: tb/tb_unidade_de_controle.sv
// Directed bench for unidade_de_controle with a behavioural 4x8 register bank.
module tb_unidade_de_controle;

    logic       clk = 1'b0;
    logic       clr;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] rd1, rd2, wd;
    logic       we, zero, carry, done, busy;
    logic [1:0] a1, a2;

    logic [7:0] regs [0:3];
    int n_cmp = 0;
    int n_err = 0;
    int we_cnt = 0;
    int pair_err = 0;

    unidade_de_controle #(.Size(8)) dut (
        .clk(clk), .clr(clr), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .rd1(rd1), .rd2(rd2), .we(we), .wd(wd),
        .a1(a1), .a2(a2), .zero(zero), .carry(carry), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    assign rd1 = regs[a1];
    assign rd2 = regs[a2];

    // Register bank write port, plus write/done pairing monitor.
    always @(posedge clk) begin
        if (we) begin
            regs[a1] <= wd;
            we_cnt <= we_cnt + 1;
        end
        if ((we && !done) || (done && busy && !we)) pair_err <= pair_err + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] w);
        bit ok = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
        n_cmp++;
        if (!ok) begin
            $display("FAIL send_timeout word=%h not accepted within 20 cycles", w);
            n_err++;
        end
    endtask

    task automatic test_reset();
        clr = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        tick(); tick();
        n_cmp++;
        if ({in_ready, busy, we, zero, carry, done, a1, a2} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0}) begin
            $display("FAIL reset rdy=%b busy=%b we=%b z=%b c=%b done=%b a1=%0d a2=%0d, want rdy=1 rest 0",
                     in_ready, busy, we, zero, carry, done, a1, a2);
            n_err++;
        end
        clr = 1'b0;
    endtask

    task automatic test_ldi_add();
        we_cnt = 0; pair_err = 0;
        send(8'h28); send(8'h5A);   // LDI R2,0x5A
        send(8'h2C); send(8'hA6);   // LDI R3,0xA6
        send(8'h6B);                // ADD R2,R3 -> now in EXEC
        n_cmp++;
        if (a1 !== 2'd2 || a2 !== 2'd3 || we !== 1'b0) begin
            $display("FAIL add_exec a1=%0d a2=%0d we=%b, want 2 3 0", a1, a2, we);
            n_err++;
        end
        tick();
        n_cmp++;
        if (we !== 1'b1 || done !== 1'b1 || wd !== 8'h00) begin
            $display("FAIL add_wb we=%b done=%b wd=%h, want 1 1 00", we, done, wd);
            n_err++;
        end
        tick();
        n_cmp++;
        if (regs[2] !== 8'h00 || regs[3] !== 8'hA6 || zero !== 1'b1 || carry !== 1'b1) begin
            $display("FAIL add_result R2=%h R3=%h z=%b c=%b, want 00 A6 1 1", regs[2], regs[3], zero, carry);
            n_err++;
        end
        n_cmp++;
        if (we_cnt !== 3 || pair_err !== 0 || in_ready !== 1'b1) begin
            $display("FAIL add_writes count=%0d pair_err=%0d rdy=%b, want 3 0 1", we_cnt, pair_err, in_ready);
            n_err++;
        end
    endtask

    task automatic test_alu_ops();
        regs[0] = 8'h03; regs[1] = 8'h05;
        send(8'h81); tick(); tick();   // SUB R0,R1
        n_cmp++;
        if (regs[0] !== 8'hFE || carry !== 1'b1 || zero !== 1'b0) begin
            $display("FAIL sub R0=%h c=%b z=%b, want FE 1 0", regs[0], carry, zero);
            n_err++;
        end
        send(8'hA0); tick(); tick();   // AND R0,R0
        n_cmp++;
        if (regs[0] !== 8'hFE || carry !== 1'b1 || zero !== 1'b0) begin
            $display("FAIL and_keeps_carry R0=%h c=%b z=%b, want FE 1 0", regs[0], carry, zero);
            n_err++;
        end
        send(8'hC4); tick(); tick();   // OR R1,R0
        n_cmp++;
        if (regs[1] !== 8'hFF || carry !== 1'b1 || zero !== 1'b0) begin
            $display("FAIL or R1=%h c=%b z=%b, want FF 1 0", regs[1], carry, zero);
            n_err++;
        end
        send(8'hED); tick(); tick();   // NOT R3,R1
        n_cmp++;
        if (regs[3] !== 8'h00 || carry !== 1'b1 || zero !== 1'b1) begin
            $display("FAIL not R3=%h c=%b z=%b, want 00 1 1", regs[3], carry, zero);
            n_err++;
        end
        regs[2] = 8'h40;
        send(8'h6A); tick(); tick();   // ADD R2,R2 without carry-out
        n_cmp++;
        if (regs[2] !== 8'h80 || carry !== 1'b0 || zero !== 1'b0) begin
            $display("FAIL add_nocarry R2=%h c=%b z=%b, want 80 0 0", regs[2], carry, zero);
            n_err++;
        end
    endtask

    task automatic test_ldi_wait();
        int bad = 0;
        we_cnt = 0;
        send(8'h24);                   // LDI R1
        for (int i = 0; i < 5; i++) begin
            tick();
            if (we !== 1'b0 || busy !== 1'b1 || in_ready !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad !== 0 || we_cnt !== 0) begin
            $display("FAIL ldi_wait bad_cycles=%0d writes=%0d, want 0 0", bad, we_cnt);
            n_err++;
        end
        send(8'h7F);
        tick();
        n_cmp++;
        if (regs[1] !== 8'h7F || we_cnt !== 1 || zero !== 1'b0) begin
            $display("FAIL ldi_late R1=%h writes=%0d z=%b, want 7F 1 0", regs[1], we_cnt, zero);
            n_err++;
        end
    endtask

    task automatic test_clr_in_wb();
        regs[0] = 8'h11; regs[1] = 8'h22;
        we_cnt = 0;
        send(8'h44); tick();           // MOV R1,R0 -> now in WB
        clr = 1'b1;
        #1;
        n_cmp++;
        if (we !== 1'b0 || done !== 1'b0) begin
            $display("FAIL clr_gate we=%b done=%b, want 0 0", we, done);
            n_err++;
        end
        tick();
        clr = 1'b0;
        #1;
        n_cmp++;
        if (regs[1] !== 8'h22 || we_cnt !== 0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL clr_abort R1=%h writes=%0d rdy=%b busy=%b, want 22 0 1 0",
                     regs[1], we_cnt, in_ready, busy);
            n_err++;
        end
    endtask

    task automatic test_nop_stream();
        int bad = 0;
        we_cnt = 0;
        in_data = 8'h1F;               // op 000, ignored and field bits set
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || we !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (bad !== 0 || we_cnt !== 0) begin
            $display("FAIL nop_stream bad_cycles=%0d writes=%0d, want 0 0", bad, we_cnt);
            n_err++;
        end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin
            $display("FAIL nop_idle done=%b, want 0", done);
            n_err++;
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) regs[i] = 8'h00;
        test_reset();
        test_ldi_add();
        test_alu_ops();
        test_ldi_wait();
        test_clr_in_wb();
        test_nop_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/unidade_de_controle.md
# unidade_de_controle

Multi-cycle controller and ALU stage sitting directly upstream of the register bank. It accepts instruction words over a valid/ready handshake, decodes them, and reads operands through the bank's two asynchronous read ports (`rd1`, `rd2`). It computes the result and writes it back through the bank's write port (`we`, `wd`, `a1`). It also exposes registered status flags and a per-instruction completion pulse.

## Interface
- `Size`, 8, data width; must match the register bank `Size`; must be ≥ 8.
- `clk`  in  1  single clock; all state updates on rising edge.
- `clr`  in  1  synchronous, active-high reset.
- `in_data`  in  Size  instruction word or LDI immediate; the instruction is decoded from `in_data[7:0]`.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `rd1`, `rd2`  in  Size  bank read data for `a1` and `a2` respectively.
- `we`  out  1  bank write enable.
- `wd`  out  Size  bank write data.
- `a1`, `a2`  out  2  bank addresses; `a1` is the destination and also the first operand, `a2` is the second operand.
- `zero`, `carry`  out  1  registered flags.
- `done`  out  1  one-cycle pulse on the writeback cycle, or on completion of a NOP.
- `busy`  out  1  high in every state except FETCH.

## Operation
- Instruction fields:
  - op = `[7:5]`
  - `[4]` is ignored
  - rdst = `[3:2]`
  - rsrc = `[1:0]`
- Opcodes:
  - 000 NOP
  - 001 LDI: next word is the immediate; R[rdst] ← imm
  - 010 MOV: R[rdst] ← R[rsrc]
  - 011 ADD: R[rdst] ← R[rdst] + R[rsrc]
  - 100 SUB: R[rdst] ← R[rdst] − R[rsrc]
  - 101 AND
  - 110 OR
  - 111 NOT: R[rdst] ← ~R[rsrc]
- FSM states: FETCH, IMM, EXEC, WB.
  - FETCH: `in_ready`=1. On `in_valid`, latch rdst/rsrc/op.
    - NOP: stay in FETCH and pulse `done` next cycle.
    - LDI: go to IMM.
    - Otherwise: go to EXEC.
  - IMM: `in_ready`=1. On `in_valid`, latch `in_data` into the result register and go to WB. Waits indefinitely otherwise.
  - EXEC: `in_ready`=0. Drive `a1`=rdst, `a2`=rsrc. Latch the ALU output of `rd1`/`rd2` into the result register. Go to WB.
  - WB: `we`=1, `wd`=result, `a1`=rdst, `done`=1. Update flags. Go to FETCH.
- Arithmetic:
  - Operations are Size bits wide and wrap modulo 2^Size.
  - ADD: `carry` = carry-out.
  - SUB: `carry` = borrow, i.e. 1 when R[rdst] < R[rsrc] unsigned.
- Flags:
  - `zero` = (result == 0) for every writing opcode.
  - `carry` is unchanged by MOV, LDI, AND, OR and NOT.
- Outputs outside the states above:
  - `we` is 0 in every state other than WB.
  - `a1`/`a2` hold their last latched values when not in EXEC or WB.
- Reset (`clr`=1 at an edge):
  - state → FETCH.
  - Latched fields, result register, `zero`, `carry`, `done` and `we` → 0.
  - `a1`/`a2` → 0.
  - After reset: `in_ready`=1, `busy`=0.
- Reset mid-instruction aborts it. No write occurs, including when reset is asserted in the WB cycle: `we` is gated by `~clr`.
- `in_valid` while `in_ready`=0 is ignored. The sender must hold the word until it is accepted.

## Timing
- All outputs are registered or decoded purely from state; there is no combinational path from `in_valid` to `we`.
- ALU ops and MOV: accept at edge N; EXEC during cycle N+1; WB during cycle N+2. The bank captures the write at the N+3 edge, and `in_ready` returns during cycle N+3.
- Throughput: one ALU instruction per 3 cycles. LDI takes 2 cycles plus the time the immediate arrives.
- Back-to-back dependency: a write committed at WB is visible on `rd1`/`rd2` during the next EXEC. No forwarding is needed.
- NOP: `done` is high the cycle after acceptance and `in_ready` stays 1, so 1 instruction per cycle.
- `done` and `we` are asserted in exactly the same cycle, except for NOP.

## Structure
- Shared package/include `unidade_de_controle_defs`, containing:
  - opcode constants OP_NOP…OP_NOT
  - state encodings S_FETCH, S_IMM, S_EXEC, S_WB
  - instruction field bit positions
- One sub-module, `ula #(Size)`: purely combinational. Inputs: op, a, b. Outputs: y, cout.
- The top-level test harness instantiates this block together with the register bank. The bank's `clr_n` is tied to `~clr`.

## Test plan
- Reset: after `clr` held for 2 cycles → `in_ready`=1, `busy`=0, `we`=0, `zero`=0, `carry`=0, `a1`=`a2`=0.
- LDI R2,0x5A, then LDI R3,0xA6, then ADD R2,R3 → R2=0x00, `zero`=1, `carry`=1, `we` asserted exactly 3 times. Each write has `done` coincident with it.
- SUB R0,R1 with R0=0x03 and R1=0x05 → R0=0xFE, `carry`=1, `zero`=0. A following AND R0,R0 leaves `carry`=1.
- LDI opcode accepted, then `in_valid` held low for 5 cycles → FSM stays in IMM with `we`=0. The immediate 0x7F then arrives → R[rdst]=0x7F two cycles later.
- `clr` asserted during the WB of MOV R1,R0 (R0=0x11, R1=0x22) → R1 stays 0x22 and the FSM returns to FETCH.
- Stream of NOP words with `in_valid` held high → 1 accepted per cycle, `done` every cycle, `we` never asserted.
